// File: rtl/gf2_div_pkg.sv
// Shared types and sizing for the GF(2) polynomial divider.
package gf2_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_e;

  localparam int DEF_N = 32;

  function automatic int cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_N);

endpackage

// File: rtl/gf2_poly_divider_if.sv
// Handshake and operand/result bundle of the GF(2) polynomial divider.
interface gf2_poly_divider_if
  import gf2_div_pkg::*;
#(
  parameter int N = DEF_N
);
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic           div_zero;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_zero, quotient, remainder
  );
endinterface

// File: rtl/gf2_deg_enc.sv
// Priority encoder: index of the highest set bit of vec_i, plus an all-zero flag.
module gf2_deg_enc #(
  parameter int N = 32,
  localparam int DW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  output logic [DW-1:0] deg_o,
  output logic          zero_o
);

  always_comb begin
    deg_o  = '0;
    zero_o = ~|vec_i;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[i]) deg_o = DW'(i);
    end
  end

endmodule

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2) polynomial divider: 2N-bit dividend / N-bit divisor, one dividend bit per clock.
// Build option: define GF2_DIV_QUOTIENT_EN to keep the quotient register; otherwise quotient is tied to 0.
module gf2_poly_divider
  import gf2_div_pkg::*;
#(
  parameter int N = DEF_N
) (
  input logic              clk,
  input logic              rst,
  gf2_poly_divider_if.slave bus
);

  localparam int CW = cnt_width(N);
  localparam int DW = (N > 1) ? $clog2(N) : 1;

  state_e         state_q, state_d;
  logic [2*N-1:0] dvd_q, dvd_d;
  logic [N-1:0]   dsr_q, dsr_d;
  logic [DW-1:0]  deg_q, deg_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dz_q, dz_d;

  logic [DW-1:0]  enc_deg;
  logic           enc_zero;
  logic [N-1:0]   win;
  logic [N-1:0]   win_red;
  logic           qbit;

  gf2_deg_enc #(.N(N)) u_deg_enc (
    .vec_i  (bus.divisor),
    .deg_o  (enc_deg),
    .zero_o (enc_zero)
  );

  // deg(r) < deg(divisor) <= N-1 keeps r[N-1] at 0, so the shifted-in
  // window fits in N bits and the t[N] overflow bit never needs storage.
  always_comb begin
    win     = {rem_q[N-2:0], dvd_q[2*N-1]};
    qbit    = win[deg_q];
    win_red = qbit ? (win ^ dsr_q) : win;
  end

`ifdef GF2_DIV_QUOTIENT_EN
  logic [2*N-1:0] quo_q, quo_d;

  always_ff @(posedge clk) begin
    if (rst) quo_q <= '0;
    else     quo_q <= quo_d;
  end

  assign bus.quotient = quo_q;
`else
  assign bus.quotient = '0;
`endif

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    deg_d   = deg_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
`ifdef GF2_DIV_QUOTIENT_EN
    quo_d   = quo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dsr_d   = bus.divisor;
          deg_d   = enc_deg;
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = enc_zero;
`ifdef GF2_DIV_QUOTIENT_EN
          quo_d   = '0;
`endif
          state_d = enc_zero ? DONE : DIV;
        end
      end
      DIV: begin
        dvd_d = {dvd_q[2*N-2:0], 1'b0};
        rem_d = win_red;
        cnt_d = cnt_q + CW'(1);
`ifdef GF2_DIV_QUOTIENT_EN
        quo_d = {quo_q[2*N-2:0], qbit};
`endif
        if (cnt_q == CW'(2 * N - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      deg_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      deg_q   <= deg_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.div_zero  = dz_q;
  assign bus.remainder = rem_q;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Self-checking bench for gf2_poly_divider (N=32): directed table, handshake corner cases, random vectors.
module tb_gf2_poly_divider;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tot  = 0;
  int   n_pass = 0;

  gf2_poly_divider_if #(.N(N)) bus ();

  gf2_poly_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [31:0] b;
    logic [63:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  function automatic logic [63:0] qexp(input logic [63:0] q);
`ifdef GF2_DIV_QUOTIENT_EN
    return q;
`else
    return 64'h0 & q;
`endif
  endfunction

  // Textbook long division: cancel the leading term with a shifted divisor.
  task automatic ref_div(input logic [63:0] a, input logic [31:0] b,
                         output logic [63:0] q, output logic [31:0] r);
    logic [63:0] rem;
    int db;
    q = '0;
    r = '0;
    if (b != 0) begin
      db = 0;
      for (int i = 0; i < 32; i++) if (b[i]) db = i;
      rem = a;
      for (int i = 63; i >= db; i--) begin
        if (rem[i]) begin
          rem = rem ^ ({32'h0, b} << (i - db));
          q[i - db] = 1'b1;
        end
      end
      r = rem[31:0];
    end
  endtask

  function automatic logic [63:0] clmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p = '0;
    for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'h0, a} << i);
    return p;
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // Accepts on the first edge, scrambles the inputs, returns edges from acceptance to done.
  task automatic run_op(input logic [63:0] a, input logic [31:0] b, output int lat);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.dividend = {$urandom, $urandom};
    bus.divisor  = $urandom;
    wait_done(lat);
  endtask

  vec_t        tbl[6];
  int          lat;
  int          done_cnt;
  logic [63:0] eq, a64, sv_q;
  logic [31:0] er, b32, a32, sv_r;

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    tbl[0] = '{64'h5, 32'h3, 64'h3, 32'h0, 1'b0, 64};
    tbl[1] = '{64'h7, 32'h3, 64'h2, 32'h1, 1'b0, 64};
    tbl[2] = '{64'hDEADBEEF01234567, 32'h1, 64'hDEADBEEF01234567, 32'h0, 1'b0, 64};
    tbl[3] = '{64'hFFFFFFFFFFFFFFFF, 32'h80000000, 64'h1FFFFFFFF, 32'h7FFFFFFF, 1'b0, 64};
    tbl[4] = '{64'h123456789ABCDEF0, 32'h0, 64'h0, 32'h0, 1'b1, 0};
    tbl[5] = '{64'h5, 32'h3, 64'h3, 32'h0, 1'b0, 64};

    // Reset, with start held high to show reset wins.
    bus.start    = 1'b1;
    bus.dividend = 64'h5;
    bus.divisor  = 32'h3;
    tick();
    tick();
    check("rst_busy", {63'h0, bus.busy}, 64'h0);
    check("rst_done", {63'h0, bus.done}, 64'h0);
    check("rst_dz", {63'h0, bus.div_zero}, 64'h0);
    check("rst_q", bus.quotient, 64'h0);
    check("rst_r", {32'h0, bus.remainder}, 64'h0);
    bus.start = 1'b0;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, lat);
      check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("tbl%0d_q", i), bus.quotient, qexp(tbl[i].q));
      check($sformatf("tbl%0d_r", i), {32'h0, bus.remainder}, {32'h0, tbl[i].r});
      check($sformatf("tbl%0d_dz", i), {63'h0, bus.div_zero}, {63'h0, tbl[i].dz});
      sv_q = bus.quotient;
      sv_r = bus.remainder;
      tick();
      check($sformatf("tbl%0d_done_pulse", i), {63'h0, bus.done}, 64'h0);
      check($sformatf("tbl%0d_busy_idle", i), {63'h0, bus.busy}, 64'h0);
      check($sformatf("tbl%0d_hold", i), bus.quotient ^ {32'h0, bus.remainder},
            sv_q ^ {32'h0, sv_r});
    end

    // Start during DONE must not be accepted.
    run_op(64'h7, 32'h3, lat);
    bus.start    = 1'b1;
    bus.dividend = 64'hFFFF;
    bus.divisor  = 32'h0;
    tick();
    bus.start = 1'b0;
    check("done_start_ign_busy", {63'h0, bus.busy}, 64'h0);
    check("done_start_ign_r", {32'h0, bus.remainder}, 64'h1);
    tick();
    check("done_start_ign_idle", {63'h0, bus.busy}, 64'h0);

    // Start with new operands at edge 5 of DIV is ignored.
    a64 = 64'hA5A5_0F0F_1234_8765;
    b32 = 32'h8000_0005;
    ref_div(a64, b32, eq, er);
    bus.dividend = a64;
    bus.divisor  = b32;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    check("midstart_busy", {63'h0, bus.busy}, 64'h1);
    bus.start    = 1'b1;
    bus.dividend = 64'h1;
    bus.divisor  = 32'h0;
    tick();
    bus.start = 1'b0;
    wait_done(lat);
    check("midstart_lat", 64'(lat + 5), 64'd64);
    check("midstart_q", bus.quotient, qexp(eq));
    check("midstart_r", {32'h0, bus.remainder}, {32'h0, er});
    check("midstart_dz", {63'h0, bus.div_zero}, 64'h0);
    tick();

    // Reset at edge 10 of DIV aborts without a done pulse.
    bus.dividend = 64'hFEDC_BA98_7654_3210;
    bus.divisor  = 32'h0000_011B;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {63'h0, bus.busy}, 64'h0);
    check("abort_done", {63'h0, bus.done}, 64'h0);
    check("abort_q", bus.quotient, 64'h0);
    check("abort_r", {32'h0, bus.remainder}, 64'h0);
    done_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      if (bus.done === 1'b1) done_cnt++;
      tick();
    end
    check("abort_no_done", 64'(done_cnt), 64'h0);

    // Random general division against the long-division model.
    for (int i = 0; i < 100; i++) begin
      a64 = {$urandom, $urandom};
      b32 = $urandom >> $urandom_range(0, 31);
      if (b32 == 0) b32 = 32'h1;
      ref_div(a64, b32, eq, er);
      run_op(a64, b32, lat);
      check($sformatf("rnd%0d_q", i), bus.quotient, qexp(eq));
      check($sformatf("rnd%0d_r", i), {32'h0, bus.remainder}, {32'h0, er});
      tick();
    end

    // Carry-less multiply round trip: (a clmul b) / b == a, remainder 0.
    for (int i = 0; i < 1000; i++) begin
      a32 = $urandom;
      b32 = $urandom;
      if (b32 == 0) b32 = 32'h1;
      run_op(clmul(a32, b32), b32, lat);
      check($sformatf("rt%0d_q", i), bus.quotient, qexp({32'h0, a32}));
      check($sformatf("rt%0d_r", i), {32'h0, bus.remainder}, 64'h0);
      if (lat != 64) check($sformatf("rt%0d_lat", i), 64'(lat), 64'd64);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
